inbuf_pingpong_v2: RTL and testbench

Parametrised successor of the tile input buffer. It accepts an AXI-Stream of 64-bit feature-map words and distributes them row by row into `Ram_Row` parallel row memories. It manages two banks as a self-arbitrating ping-pong pair with full/release handshakes, and serves parallel reads with left/right zero padding applied in hardware. It sits between the DMA stream and the PE-array read port.

---
 rtl/inbuf_pingpong_v2_if.sv | 17 +
 rtl/inbuf_pingpong_v2.sv | 194 +++++++++++++++++++
 tb/tb_inbuf_pingpong_v2.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inbuf_pingpong_v2_if.sv
// inbuf_pingpong_v2_if
// AXI-Stream slave-side bundle feeding the ping-pong input buffer.
//   tdata  : stream word
//   tvalid : producer has a word
//   tlast  : final beat of a fill
//   tready : buffer accepts the word
interface inbuf_pingpong_v2_if #(
  parameter int Data_Width = 64
) ();
  logic [Data_Width-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/inbuf_pingpong_v2.sv
// inbuf_pingpong_v2
// Tile input buffer: distributes an AXI-Stream row by row into Ram_Row
// parallel row memories across two self-arbitrating ping-pong banks, and
// serves wide parallel reads with left/right zero padding.
// Optional build macro: INBUF_OREG_EN adds an output register stage after
// the memory (read latency 2 instead of 1).
// Ports:
//   clk, rst_n         clock, async active-low reset
//   i_cfg_*            fill request and descriptor (words, rows, left pad)
//   s_axis             stream input (slave modport)
//   i_rd_en/i_rd_addr  read strobe and logical address (padding included)
//   i_rd_release       reader done with current read bank
//   o_rd_dout/o_rd_valid  all lanes, lane i at [Data_Width*i +: Data_Width]
//   o_wr_bank/o_rd_bank/o_bank_full/o_fill_done/o_err_tlast  status
//
// Write FSM:
//   state  | meaning
//   W_IDLE | waiting for cfg request on a free write bank
//   W_FILL | accepting stream beats into the write bank
//   W_WAIT | both banks full, stream stalled until a release
module inbuf_pingpong_v2 #(
  parameter int Ram_Row       = 33,
  parameter int Data_Width    = 64,
  parameter int Addr_Width    = 9,
  parameter int Row_Cnt_Width = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_cfg_valid,
  input  logic [Addr_Width-1:0]         i_cfg_words,
  input  logic [Row_Cnt_Width-1:0]      i_cfg_rows,
  input  logic [Addr_Width-1:0]         i_cfg_pad_lef,
  inbuf_pingpong_v2_if.slave            s_axis,
  input  logic                          i_rd_en,
  input  logic [Addr_Width-1:0]         i_rd_addr,
  input  logic                          i_rd_release,
  output logic [Data_Width*Ram_Row-1:0] o_rd_dout,
  output logic                          o_rd_valid,
  output logic                          o_wr_bank,
  output logic                          o_rd_bank,
  output logic [1:0]                    o_bank_full,
  output logic                          o_fill_done,
  output logic                          o_err_tlast
);

  localparam int Depth = 2**Addr_Width;
  localparam logic [Addr_Width-1:0]    ONE_A = 1;
  localparam logic [Row_Cnt_Width-1:0] ONE_R = 1;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} state_t;

  state_t r_state, w_state_nxt;

  logic [Data_Width-1:0]    r_mem [2][Ram_Row][Depth];
  logic [Addr_Width-1:0]    r_desc_words [2];
  logic [Row_Cnt_Width-1:0] r_desc_rows  [2];
  logic [Addr_Width-1:0]    r_desc_pad   [2];

  logic [Addr_Width-1:0]    r_word_cnt;
  logic [Row_Cnt_Width-1:0] r_row_cnt;
  logic                     r_wr_bank, r_rd_bank;
  logic [1:0]               r_full, w_full_nxt;
  logic                     r_tready, r_fill_done, r_err;
  logic [Data_Width*Ram_Row-1:0] r_dout1;
  logic                     r_valid1;

  logic w_cfg_acc, w_hs, w_word_last, w_is_last, w_last_beat, w_rel;
  logic w_rd_zero;
  logic [Addr_Width-1:0] w_p;

  assign w_cfg_acc   = (r_state == W_IDLE) && i_cfg_valid && !r_full[r_wr_bank];
  assign w_hs        = (r_state == W_FILL) && s_axis.tvalid;
  assign w_word_last = r_word_cnt == (r_desc_words[r_wr_bank] - ONE_A);
  assign w_is_last   = w_word_last && (r_row_cnt == (r_desc_rows[r_wr_bank] - ONE_R));
  assign w_last_beat = w_hs && w_is_last;
  // a release only counts against a full bank; during a fill the two banks differ
  assign w_rel       = i_rd_release && r_full[r_rd_bank];

  always_comb begin
    w_full_nxt = r_full;
    if (w_last_beat) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rel)       w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      W_IDLE: if (w_cfg_acc) w_state_nxt = W_FILL;
      // the bank being switched to may be released in this very cycle
      W_FILL: if (w_last_beat) w_state_nxt = w_full_nxt[~r_wr_bank] ? W_WAIT : W_IDLE;
      W_WAIT: if (!w_full_nxt[r_wr_bank]) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= W_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tready    <= 1'b0;
      r_full      <= 2'b00;
      r_fill_done <= 1'b0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_err       <= 1'b0;
      r_word_cnt  <= '0;
      r_row_cnt   <= '0;
      for (int b = 0; b < 2; b++) begin
        r_desc_words[b] <= '0;
        r_desc_rows[b]  <= '0;
        r_desc_pad[b]   <= '0;
      end
    end else begin
      r_tready    <= (w_state_nxt == W_FILL);
      r_full      <= w_full_nxt;
      r_fill_done <= w_last_beat;
      if (w_last_beat) r_wr_bank <= ~r_wr_bank;
      if (w_rel)       r_rd_bank <= ~r_rd_bank;
      if (w_hs && (s_axis.tlast != w_is_last)) r_err <= 1'b1;
      if (w_cfg_acc) begin
        r_desc_words[r_wr_bank] <= i_cfg_words;
        r_desc_rows[r_wr_bank]  <= i_cfg_rows;
        r_desc_pad[r_wr_bank]   <= i_cfg_pad_lef;
        r_word_cnt <= '0;
        r_row_cnt  <= '0;
      end else if (w_hs) begin
        if (w_word_last) begin
          r_word_cnt <= '0;
          r_row_cnt  <= r_row_cnt + ONE_R;
        end else begin
          r_word_cnt <= r_word_cnt + ONE_A;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) r_mem[r_wr_bank][r_row_cnt][r_word_cnt] <= s_axis.tdata;
  end

  // left-pad compare happens on the raw address, so the subtract never wraps into range
  assign w_p       = i_rd_addr - r_desc_pad[r_rd_bank];
  assign w_rd_zero = !r_full[r_rd_bank] || (i_rd_addr < r_desc_pad[r_rd_bank]) ||
                     (w_p >= r_desc_words[r_rd_bank]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout1  <= '0;
      r_valid1 <= 1'b0;
    end else begin
      r_valid1 <= i_rd_en;
      if (i_rd_en) begin
        for (int i = 0; i < Ram_Row; i++) begin
          if (w_rd_zero || (Row_Cnt_Width'(i) >= r_desc_rows[r_rd_bank]))
            r_dout1[Data_Width*i +: Data_Width] <= '0;
          else
            r_dout1[Data_Width*i +: Data_Width] <= r_mem[r_rd_bank][i][w_p];
        end
      end
    end
  end

`ifdef INBUF_OREG_EN
  logic [Data_Width*Ram_Row-1:0] r_dout2;
  logic                          r_valid2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout2  <= '0;
      r_valid2 <= 1'b0;
    end else begin
      r_dout2  <= r_dout1;
      r_valid2 <= r_valid1;
    end
  end

  assign o_rd_dout  = r_dout2;
  assign o_rd_valid = r_valid2;
`else
  assign o_rd_dout  = r_dout1;
  assign o_rd_valid = r_valid1;
`endif

  assign s_axis.tready = r_tready;
  assign o_wr_bank     = r_wr_bank;
  assign o_rd_bank     = r_rd_bank;
  assign o_bank_full   = r_full;
  assign o_fill_done   = r_fill_done;
  assign o_err_tlast   = r_err;

endmodule

// File: tb/tb_inbuf_pingpong_v2.sv
// tb_inbuf_pingpong_v2
// Randomized bench for inbuf_pingpong_v2 against a beat-indexed model of
// each bank's contents and the ping-pong bank flags.
module tb_inbuf_pingpong_v2;
  localparam int RR = 33;
  localparam int DW = 64;
`ifdef INBUF_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 0;
  logic rst_n = 0;
  logic i_cfg_valid = 0;
  logic [8:0] i_cfg_words = 0;
  logic [5:0] i_cfg_rows = 0;
  logic [8:0] i_cfg_pad_lef = 0;
  logic i_rd_en = 0;
  logic [8:0] i_rd_addr = 0;
  logic i_rd_release = 0;
  logic [DW*RR-1:0] o_rd_dout;
  logic o_rd_valid, o_wr_bank, o_rd_bank, o_fill_done, o_err_tlast;
  logic [1:0] o_bank_full;

  inbuf_pingpong_v2_if #(.Data_Width(DW)) s_axis_if ();

  inbuf_pingpong_v2 dut (
    .clk(clk), .rst_n(rst_n),
    .i_cfg_valid(i_cfg_valid), .i_cfg_words(i_cfg_words), .i_cfg_rows(i_cfg_rows),
    .i_cfg_pad_lef(i_cfg_pad_lef), .s_axis(s_axis_if),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .i_rd_release(i_rd_release),
    .o_rd_dout(o_rd_dout), .o_rd_valid(o_rd_valid), .o_wr_bank(o_wr_bank),
    .o_rd_bank(o_rd_bank), .o_bank_full(o_bank_full), .o_fill_done(o_fill_done),
    .o_err_tlast(o_err_tlast)
  );

  always #5 clk = ~clk;

  // reference model
  logic [63:0] m_data [2][1024];
  int  m_words [2];
  int  m_rows  [2];
  int  m_pad   [2];
  bit [1:0] m_full;
  bit  m_wr, m_rd, m_err;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_full = 2'b00; m_wr = 0; m_rd = 0; m_err = 0;
  endtask

  function automatic logic [63:0] exp_lane(int i, int addr);
    int b;
    b = int'(m_rd);
    if (!m_full[b] || addr < m_pad[b] || addr - m_pad[b] >= m_words[b] || i >= m_rows[b])
      return 64'd0;
    return m_data[b][i*m_words[b] + addr - m_pad[b]];
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, "_full"}, 64'(o_bank_full), 64'(m_full));
    chk({tag, "_wr"}, 64'(o_wr_bank), 64'(m_wr));
    chk({tag, "_rd"}, 64'(o_rd_bank), 64'(m_rd));
    chk({tag, "_err"}, 64'(o_err_tlast), 64'(m_err));
  endtask

  task automatic do_read(input int addr);
    i_rd_en = 1; i_rd_addr = 9'(addr);
    step();
    i_rd_en = 0;
    if (LAT == 2) begin
      chk("rd_valid_early", 64'(o_rd_valid), 64'd0);
      step();
    end
    chk("rd_valid", 64'(o_rd_valid), 64'd1);
    for (int i = 0; i < RR; i++)
      chk($sformatf("rd_lane%0d_a%0d", i, addr), o_rd_dout[DW*i +: DW], exp_lane(i, addr));
    step();
    chk("rd_valid_pulse", 64'(o_rd_valid), 64'd0);
  endtask

  task automatic do_release();
    i_rd_release = 1;
    step();
    i_rd_release = 0;
    if (m_full[m_rd]) begin
      m_full[m_rd] = 0;
      m_rd = !m_rd;
    end
    chk_status("rel");
  endtask

  task automatic do_fill(input int words, input int rows, input int pad,
                         input bit seq, input int bad, input bit rel_last);
    int total, n, guard;
    bit v, hs, b;
    logic [63:0] d;
    b = m_wr;
    total = words * rows;
    i_cfg_words = 9'(words); i_cfg_rows = 6'(rows); i_cfg_pad_lef = 9'(pad);
    i_cfg_valid = 1;
    step();
    i_cfg_valid = 0;
    chk("tready_rise", 64'(s_axis_if.tready), 64'd1);
    n = 0; guard = 0;
    while (n < total && guard < 4*total + 50) begin
      v = seq || ($urandom % 4 != 0);
      d = seq ? 64'(n) : {$urandom, $urandom};
      s_axis_if.tdata  = d;
      s_axis_if.tvalid = v;
      s_axis_if.tlast  = v && ((n == total-1) != (n == bad));
      i_rd_release     = rel_last && v && (n == total-1);
      hs = v && s_axis_if.tready;
      step();
      if (hs) begin
        m_data[b][n] = d;
        n++;
      end
      guard++;
    end
    s_axis_if.tvalid = 0; s_axis_if.tlast = 0; i_rd_release = 0;
    chk("fill_count", 64'(n), 64'(total));
    if (rel_last && m_full[m_rd]) begin
      m_full[m_rd] = 0;
      m_rd = !m_rd;
    end
    m_full[b] = 1;
    m_wr = !b;
    m_words[b] = words; m_rows[b] = rows; m_pad[b] = pad;
    if (bad >= 0 && bad < total) m_err = 1;
    chk("fill_done", 64'(o_fill_done), 64'd1);
    chk("tready_fall", 64'(s_axis_if.tready), 64'd0);
    chk_status("fill");
    step();
    chk("fill_done_pulse", 64'(o_fill_done), 64'd0);
  endtask

  task automatic rand_fill(input bit rel_last);
    int w, r, bad;
    w = $urandom_range(1, 16);
    r = $urandom_range(1, RR);
    bad = ($urandom % 4 == 0) ? $urandom_range(0, w*r-1) : -1;
    do_fill(w, r, $urandom_range(0, 3), 0, bad, rel_last);
  endtask

  task automatic rand_reads(input int cnt);
    int b;
    b = int'(m_rd);
    for (int k = 0; k < cnt; k++)
      do_read($urandom_range(0, m_pad[b] + m_words[b] + 2));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axis_if.tdata = 0; s_axis_if.tvalid = 0; s_axis_if.tlast = 0;
    for (int b = 0; b < 2; b++) begin
      m_words[b] = 1; m_rows[b] = 1; m_pad[b] = 0;
    end
    model_reset();
    repeat (3) step();
    chk("rst_tready", 64'(s_axis_if.tready), 64'd0);
    chk("rst_valid", 64'(o_rd_valid), 64'd0);
    chk("rst_dout", 64'(|o_rd_dout), 64'd0);
    chk("rst_fill_done", 64'(o_fill_done), 64'd0);
    chk_status("rst");
    rst_n = 1;
    step();

    // basic fill, value n
    do_fill(4, 3, 0, 1, -1, 0);
    chk("tp_full01", 64'(o_bank_full), 64'b01);
    chk("tp_wr1", 64'(o_wr_bank), 64'd1);
    i_rd_en = 1; i_rd_addr = 9'd2;
    step();
    i_rd_en = 0;
    if (LAT == 2) step();
    chk("tp_lane0", o_rd_dout[0 +: 64], 64'd2);
    chk("tp_lane1", o_rd_dout[64 +: 64], 64'd6);
    chk("tp_lane2", o_rd_dout[128 +: 64], 64'd10);
    chk("tp_lane3", o_rd_dout[192 +: 64], 64'd0);
    step();
    do_read(2); do_read(3); do_read(4);

    // release bank 0, read from non-full bank 1
    do_release();
    do_read(1);

    // left pad 1 in bank 1, then fill bank 0 so both are full
    do_fill(4, 3, 1, 1, -1, 0);
    do_read(0); do_read(1); do_read(4); do_read(5);
    rand_fill(0);
    chk("wait_tready", 64'(s_axis_if.tready), 64'd0);
    i_cfg_valid = 1;
    step();
    i_cfg_valid = 0;
    step();
    chk("wait_cfg_ignored", 64'(s_axis_if.tready), 64'd0);
    do_release();
    rand_reads(3);

    // last beat coincides with release
    do_fill(3, 2, 0, 0, -1, 1);
    chk("coinc_full10", 64'(o_bank_full), 64'b10);
    rand_reads(3);

    // tlast on beat 5 of 12
    do_release();
    do_fill(4, 3, 0, 1, 4, 0);
    chk("tlast_err_set", 64'(o_err_tlast), 64'd1);
    do_release();
    do_fill(2, 2, 0, 0, -1, 0);
    chk("tlast_err_sticky", 64'(o_err_tlast), 64'd1);

    // randomized mix
    for (int it = 0; it < 16; it++) begin
      case ($urandom % 3)
        0: if (!m_full[m_wr]) rand_fill($urandom % 2 == 1); else do_release();
        1: do_release();
        default: rand_reads(2);
      endcase
    end

    // reset in the middle of a fill
    for (int k = 0; k < 3 && m_full[m_wr]; k++) do_release();
    i_cfg_words = 9'd4; i_cfg_rows = 6'd3; i_cfg_pad_lef = 9'd0;
    i_cfg_valid = 1;
    step();
    i_cfg_valid = 0;
    s_axis_if.tvalid = 1;
    for (int k = 0; k < 6; k++) begin
      s_axis_if.tdata = 64'(k);
      step();
    end
    s_axis_if.tvalid = 0;
    chk("pre_rst_err", 64'(o_err_tlast), 64'(m_err));
    rst_n = 0;
    #1;
    model_reset();
    chk("midrst_tready", 64'(s_axis_if.tready), 64'd0);
    chk_status("midrst");
    step();
    rst_n = 1;
    step();
    chk("postrst_full", 64'(o_bank_full), 64'd0);
    chk("postrst_tready", 64'(s_axis_if.tready), 64'd0);
    do_read(0);
    rand_fill(0);
    rand_reads(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
